vga_sincronismo: RTL and testbench
==================================

Name: vga_sincronismo

Overview:
- Generates 640x480@60 Hz VGA timing for the Batalha Naval display.
- Drives the linha/coluna/areaAtiva raster bus consumed by the per-ship VGA renderers.
- Drives the hsync/vsync pins directly.
- Provides a pixel enable, a frame-start pulse and a frame counter, used by renderers for blink and animation effects.

Parameters:
- H_VISIVEL, 640, visible columns
- H_FRENTE, 16, horizontal front porch (pixels)
- H_PULSO, 96, hsync pulse width (pixels)
- H_TRAS, 48, horizontal back porch (pixels)
- V_VISIVEL, 480, visible lines
- V_FRENTE, 10, vertical front porch (lines)
- V_PULSO, 2, vsync pulse width (lines)
- V_TRAS, 33, vertical back porch (lines)
- DIV_PIXEL, 2, clk cycles per pixel; 50 MHz clk gives 25 MHz pixel rate; legal range >=1

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pixel_en  out  1  one-clk strobe, high on the clk cycle in which counters advance
- coluna  out  10  current pixel column, 0..H_TOTAL-1
- linha  out  10  current line, 0..V_TOTAL-1
- areaAtiva  out  1  high when coluna<H_VISIVEL and linha<V_VISIVEL
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- inicioQuadro  out  1  one-clk pulse when the raster wraps to (0,0)
- quadro  out  8  frame counter, incremented on each wrap

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high: sampled only on the clk rising edge.
- Derived constants:
  - H_TOTAL = H_VISIVEL + H_FRENTE + H_PULSO + H_TRAS (default 800)
  - V_TOTAL = V_VISIVEL + V_FRENTE + V_PULSO + V_TRAS (default 525)
- Reset values, held while reset=1:
  - divider=0, coluna=0, linha=0, quadro=0
  - pixel_en=0, inicioQuadro=0, areaAtiva=0
  - hsync=1, vsync=1
- Pixel divider:
  - Counts 0..DIV_PIXEL-1; tick when it equals DIV_PIXEL-1, then wraps to 0.
  - DIV_PIXEL=1 gives a tick every clk.
- On a tick:
  - coluna increments.
  - At coluna=H_TOTAL-1: coluna wraps to 0 and linha increments.
  - At linha=V_TOTAL-1 with coluna wrapping: linha wraps to 0 and quadro increments (modulo 256, 255->0).
- Registered outputs:
  - pixel_en is registered: it is high in the clk cycle immediately after the edge on which counters changed, so it marks the first cycle of a new pixel.
  - areaAtiva, hsync and vsync are registered decodes of the next counter values, so they are always coherent with linha/coluna on the same cycle.
  - Zero skew between the raster bus and the sync outputs.
- Decodes:
  - hsync=0 iff H_VISIVEL+H_FRENTE <= coluna < H_VISIVEL+H_FRENTE+H_PULSO (656..751).
  - vsync=0 iff V_VISIVEL+V_FRENTE <= linha < V_VISIVEL+V_FRENTE+V_PULSO (490..491), for every column of those lines.
- inicioQuadro:
  - High for exactly one clk, in the cycle where linha/coluna first show (0,0) after a wrap.
  - Coincides with the corresponding pixel_en.
  - Not asserted on reset release.
- First rising edge with reset=0: areaAtiva becomes 1 (position 0,0 is visible); hsync=1, vsync=1. Counters start advancing after DIV_PIXEL clks.
- Reset mid-frame: next edge forces all reset values regardless of position. No partial pulse persists.
- Outputs never exceed H_TOTAL-1 / V_TOTAL-1; no other illegal states are reachable.

Decomposition:
- Shared package vga_pkg:
  - Default timing constants (H_*/V_* values).
  - Widths: LARGURA_COORD=10, LARGURA_QUADRO=8.
  - Grid geometry constants shared with the ship renderers: cell width 54, height 49.
- One natural sub-module: vga_divisor_pixel, the parameterised DIV_PIXEL strobe generator with synchronous reset.

Test Plan:
- Reset held 5 clk, then released -> during reset coluna=0, linha=0, hsync=1, vsync=1, areaAtiva=0; one edge after release areaAtiva=1; coluna=1 after 2 clk (DIV_PIXEL=2).
- Run one line -> coluna goes 639->640 and areaAtiva falls on the same cycle; hsync low for exactly 96 ticks = 192 clk (coluna 656..751); line period 1600 clk.
- Run full frame -> vsync low exactly on linha 490..491 (3200 clk); frame period 840000 clk; inicioQuadro one 1-clk pulse per frame at (0,0); quadro 0->1.
- Run 256 frames (or preload) -> quadro wraps 255->0 on the same cycle as inicioQuadro.
- Assert reset at linha=300, coluna=400 -> next edge all outputs at reset values; no inicioQuadro pulse; timing restarts as in scenario 1.
- DIV_PIXEL=1 build -> pixel_en constantly 1 after reset; line period 800 clk; frame period 420000 clk.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions for the Batalha Naval display.
// Holds the default 640x480@60 Hz timing, the raster bus widths, the board
// cell geometry used by the ship renderers, and a helper that sizes counters.
package vga_pkg;

  // Default horizontal timing, in pixels.
  localparam int VGA_H_VISIVEL = 640;
  localparam int VGA_H_FRENTE  = 16;
  localparam int VGA_H_PULSO   = 96;
  localparam int VGA_H_TRAS    = 48;

  // Default vertical timing, in lines.
  localparam int VGA_V_VISIVEL = 480;
  localparam int VGA_V_FRENTE  = 10;
  localparam int VGA_V_PULSO   = 2;
  localparam int VGA_V_TRAS    = 33;

  // Raster bus widths.
  localparam int LARGURA_COORD  = 10;
  localparam int LARGURA_QUADRO = 8;

  // Board cell geometry shared with the ship renderers.
  localparam int CELULA_LARGURA = 54;
  localparam int CELULA_ALTURA  = 49;

  // Width of a counter that runs 0..modulo-1; never narrower than one bit.
  function automatic int largura_contador(input int modulo);
    return (modulo > 1) ? $clog2(modulo) : 1;
  endfunction

endpackage

// File: rtl/vga_divisor_pixel.sv
// Pixel-rate strobe generator.
// Counts clk cycles 0..DIV_PIXEL-1 and raises tick during the cycle in which
// the count sits at DIV_PIXEL-1, so the raster advances once per pixel.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high reset (count returns to 0)
//   tick  - high for one clk out of every DIV_PIXEL
module vga_divisor_pixel
  import vga_pkg::*;
#(
  parameter int DIV_PIXEL = 2
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int                 LARGURA = largura_contador(DIV_PIXEL);
  localparam logic [LARGURA-1:0] ULTIMO  = LARGURA'(DIV_PIXEL - 1);

  logic [LARGURA-1:0] contagem_r;

  // With DIV_PIXEL=1 the count is stuck at 0 == ULTIMO, so tick is constant.
  assign tick = (contagem_r == ULTIMO);

  // Divider count: wraps to zero on the tick cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      contagem_r <= {LARGURA{1'b0}};
    end else if (tick) begin
      contagem_r <= {LARGURA{1'b0}};
    end else begin
      contagem_r <= contagem_r + {{(LARGURA-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/vga_sincronismo.sv
// VGA raster timing generator for the Batalha Naval display.
// Walks coluna/linha across the full frame at the pixel rate and produces the
// sync pins plus helpers for the renderers. Every output is registered from
// the next counter values, so the raster bus and the sync pins never skew.
// Ports:
//   clk, reset    - system clock, synchronous active-high reset
//   pixel_en      - high in the first clk of each new pixel
//   coluna, linha - current raster position
//   areaAtiva     - position is inside the visible window
//   hsync, vsync  - active-low sync pulses
//   inicioQuadro  - one-clk pulse when the raster wraps back to (0,0)
//   quadro        - frame counter, increments on each wrap (mod 256)
module vga_sincronismo
  import vga_pkg::*;
#(
  parameter int H_VISIVEL = VGA_H_VISIVEL,
  parameter int H_FRENTE  = VGA_H_FRENTE,
  parameter int H_PULSO   = VGA_H_PULSO,
  parameter int H_TRAS    = VGA_H_TRAS,
  parameter int V_VISIVEL = VGA_V_VISIVEL,
  parameter int V_FRENTE  = VGA_V_FRENTE,
  parameter int V_PULSO   = VGA_V_PULSO,
  parameter int V_TRAS    = VGA_V_TRAS,
  parameter int DIV_PIXEL = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      pixel_en,
  output logic [LARGURA_COORD-1:0]  coluna,
  output logic [LARGURA_COORD-1:0]  linha,
  output logic                      areaAtiva,
  output logic                      hsync,
  output logic                      vsync,
  output logic                      inicioQuadro,
  output logic [LARGURA_QUADRO-1:0] quadro
);

  localparam int H_TOTAL = H_VISIVEL + H_FRENTE + H_PULSO + H_TRAS;
  localparam int V_TOTAL = V_VISIVEL + V_FRENTE + V_PULSO + V_TRAS;

  localparam logic [LARGURA_COORD-1:0] COL_ULTIMA = LARGURA_COORD'(H_TOTAL - 1);
  localparam logic [LARGURA_COORD-1:0] LIN_ULTIMA = LARGURA_COORD'(V_TOTAL - 1);
  localparam logic [LARGURA_COORD-1:0] COL_VIS    = LARGURA_COORD'(H_VISIVEL);
  localparam logic [LARGURA_COORD-1:0] LIN_VIS    = LARGURA_COORD'(V_VISIVEL);
  localparam logic [LARGURA_COORD-1:0] HS_INICIO  = LARGURA_COORD'(H_VISIVEL + H_FRENTE);
  localparam logic [LARGURA_COORD-1:0] HS_FIM     = LARGURA_COORD'(H_VISIVEL + H_FRENTE + H_PULSO);
  localparam logic [LARGURA_COORD-1:0] VS_INICIO  = LARGURA_COORD'(V_VISIVEL + V_FRENTE);
  localparam logic [LARGURA_COORD-1:0] VS_FIM     = LARGURA_COORD'(V_VISIVEL + V_FRENTE + V_PULSO);
  localparam logic [LARGURA_COORD-1:0] COORD_UM   = LARGURA_COORD'(1);
  localparam logic [LARGURA_QUADRO-1:0] QUADRO_UM = LARGURA_QUADRO'(1);

  logic                      tick_s;
  logic [LARGURA_COORD-1:0]  coluna_prox_s;
  logic [LARGURA_COORD-1:0]  linha_prox_s;
  logic [LARGURA_QUADRO-1:0] quadro_prox_s;
  logic                      fim_quadro_s;
  logic                      area_prox_s;
  logic                      hsync_prox_s;
  logic                      vsync_prox_s;

  logic                      pixel_en_r;
  logic [LARGURA_COORD-1:0]  coluna_r;
  logic [LARGURA_COORD-1:0]  linha_r;
  logic                      area_r;
  logic                      hsync_r;
  logic                      vsync_r;
  logic                      inicio_r;
  logic [LARGURA_QUADRO-1:0] quadro_r;

  vga_divisor_pixel #(
    .DIV_PIXEL(DIV_PIXEL)
  ) u_divisor (
    .clk  (clk),
    .reset(reset),
    .tick (tick_s)
  );

  // Next raster position and frame count; only moves on a pixel tick.
  always_comb begin
    coluna_prox_s = coluna_r;
    linha_prox_s  = linha_r;
    quadro_prox_s = quadro_r;
    fim_quadro_s  = 1'b0;
    if (tick_s) begin
      if (coluna_r == COL_ULTIMA) begin
        coluna_prox_s = {LARGURA_COORD{1'b0}};
        if (linha_r == LIN_ULTIMA) begin
          linha_prox_s  = {LARGURA_COORD{1'b0}};
          quadro_prox_s = quadro_r + QUADRO_UM;
          fim_quadro_s  = 1'b1;
        end else begin
          linha_prox_s = linha_r + COORD_UM;
        end
      end else begin
        coluna_prox_s = coluna_r + COORD_UM;
      end
    end else begin
      fim_quadro_s = 1'b0;
    end
  end

  // Decodes of the next position, registered below alongside the counters.
  always_comb begin
    area_prox_s  = (coluna_prox_s < COL_VIS) && (linha_prox_s < LIN_VIS);
    hsync_prox_s = !((coluna_prox_s >= HS_INICIO) && (coluna_prox_s < HS_FIM));
    vsync_prox_s = !((linha_prox_s >= VS_INICIO) && (linha_prox_s < VS_FIM));
  end

  // Output registers: counters, strobes and sync decodes all update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_en_r <= 1'b0;
      coluna_r   <= {LARGURA_COORD{1'b0}};
      linha_r    <= {LARGURA_COORD{1'b0}};
      area_r     <= 1'b0;
      hsync_r    <= 1'b1;
      vsync_r    <= 1'b1;
      inicio_r   <= 1'b0;
      quadro_r   <= {LARGURA_QUADRO{1'b0}};
    end else begin
      pixel_en_r <= tick_s;
      coluna_r   <= coluna_prox_s;
      linha_r    <= linha_prox_s;
      area_r     <= area_prox_s;
      hsync_r    <= hsync_prox_s;
      vsync_r    <= vsync_prox_s;
      // Only a real wrap pulses; reset release leaves this low.
      inicio_r   <= fim_quadro_s;
      quadro_r   <= quadro_prox_s;
    end
  end

  assign pixel_en     = pixel_en_r;
  assign coluna       = coluna_r;
  assign linha        = linha_r;
  assign areaAtiva    = area_r;
  assign hsync        = hsync_r;
  assign vsync        = vsync_r;
  assign inicioQuadro = inicio_r;
  assign quadro       = quadro_r;

endmodule

// File: tb/tb_vga_sincronismo.sv
// Self-checking bench for vga_sincronismo.
// Three instances share clk/reset: A (small frame, DIV_PIXEL=2),
// B (small frame, DIV_PIXEL=1) and C (default 640x480 timing, DIV_PIXEL=2).
// Expected outputs come from a closed-form model: after n clk edges since
// reset release, n/DIV pixels have elapsed, and every output follows from
// that pixel index with plain arithmetic.
module tb_vga_sincronismo;

  typedef struct packed {
    logic       pe;
    logic [9:0] col;
    logic [9:0] lin;
    logic       area;
    logic       hs;
    logic       vs;
    logic       ini;
    logic [7:0] qd;
  } saida_t;

  typedef struct packed {
    logic   rst;
    saida_t esp;
  } vetor_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int testes = 0;
  int falhas = 0;
  int n = 0;

  logic       pe_a, area_a, hs_a, vs_a, ini_a;
  logic [9:0] col_a, lin_a;
  logic [7:0] qd_a;
  logic       pe_b, area_b, hs_b, vs_b, ini_b;
  logic [9:0] col_b, lin_b;
  logic [7:0] qd_b;
  logic       pe_c, area_c, hs_c, vs_c, ini_c;
  logic [9:0] col_c, lin_c;
  logic [7:0] qd_c;

  saida_t sa, sb, sc;
  assign sa = {pe_a, col_a, lin_a, area_a, hs_a, vs_a, ini_a, qd_a};
  assign sb = {pe_b, col_b, lin_b, area_b, hs_b, vs_b, ini_b, qd_b};
  assign sc = {pe_c, col_c, lin_c, area_c, hs_c, vs_c, ini_c, qd_c};

  vga_sincronismo #(
    .H_VISIVEL(6), .H_FRENTE(1), .H_PULSO(2), .H_TRAS(1),
    .V_VISIVEL(3), .V_FRENTE(1), .V_PULSO(1), .V_TRAS(1), .DIV_PIXEL(2)
  ) dut_a (
    .clk(clk), .reset(reset), .pixel_en(pe_a), .coluna(col_a), .linha(lin_a),
    .areaAtiva(area_a), .hsync(hs_a), .vsync(vs_a), .inicioQuadro(ini_a), .quadro(qd_a)
  );

  vga_sincronismo #(
    .H_VISIVEL(4), .H_FRENTE(1), .H_PULSO(1), .H_TRAS(2),
    .V_VISIVEL(2), .V_FRENTE(1), .V_PULSO(1), .V_TRAS(1), .DIV_PIXEL(1)
  ) dut_b (
    .clk(clk), .reset(reset), .pixel_en(pe_b), .coluna(col_b), .linha(lin_b),
    .areaAtiva(area_b), .hsync(hs_b), .vsync(vs_b), .inicioQuadro(ini_b), .quadro(qd_b)
  );

  vga_sincronismo #(
    .DIV_PIXEL(2)
  ) dut_c (
    .clk(clk), .reset(reset), .pixel_en(pe_c), .coluna(col_c), .linha(lin_c),
    .areaAtiva(area_c), .hsync(hs_c), .vsync(vs_c), .inicioQuadro(ini_c), .quadro(qd_c)
  );

  function automatic saida_t valores_reset();
    saida_t s;
    s = '{pe: 1'b0, col: 10'd0, lin: 10'd0, area: 1'b0, hs: 1'b1, vs: 1'b1, ini: 1'b0, qd: 8'd0};
    return s;
  endfunction

  // Reference model: outputs after n edges since reset release.
  function automatic saida_t modelo(input int nn, input int hv, input int hf, input int hp,
                                    input int hb, input int vv, input int vf, input int vp,
                                    input int vb, input int dv);
    saida_t s;
    int ht, vt, pix, pos, c, l;
    if (nn == 0) return valores_reset();
    ht  = hv + hf + hp + hb;
    vt  = vv + vf + vp + vb;
    pix = nn / dv;
    pos = pix % (ht * vt);
    c   = pos % ht;
    l   = pos / ht;
    s.pe   = ((nn % dv) == 0);
    s.col  = 10'(c);
    s.lin  = 10'(l);
    s.area = (c < hv) && (l < vv);
    s.hs   = !((c >= hv + hf) && (c < hv + hf + hp));
    s.vs   = !((l >= vv + vf) && (l < vv + vf + vp));
    s.ini  = s.pe && (pos == 0);
    s.qd   = 8'((pix / (ht * vt)) % 256);
    return s;
  endfunction

  function automatic saida_t mk(input logic pe, input int c, input logic area, input logic hs);
    saida_t s;
    s = '{pe: pe, col: 10'(c), lin: 10'd0, area: area, hs: hs, vs: 1'b1, ini: 1'b0, qd: 8'd0};
    return s;
  endfunction

  task automatic cmp(input string nome, input saida_t at, input saida_t esp);
    testes++;
    if (at !== esp) begin
      falhas++;
      $display("FAIL %s n=%0d: got pe=%0b col=%0d lin=%0d area=%0b hs=%0b vs=%0b ini=%0b qd=%0d, expected pe=%0b col=%0d lin=%0d area=%0b hs=%0b vs=%0b ini=%0b qd=%0d",
               nome, n, at.pe, at.col, at.lin, at.area, at.hs, at.vs, at.ini, at.qd,
               esp.pe, esp.col, esp.lin, esp.area, esp.hs, esp.vs, esp.ini, esp.qd);
    end
  endtask

  task automatic cmp_int(input string nome, input int at, input int esp);
    testes++;
    if (at != esp) begin
      falhas++;
      $display("FAIL %s: got %0d, expected %0d", nome, at, esp);
    end
  endtask

  // One clk: drive reset, sample after the edge, check all three against the model.
  task automatic passo(input logic r);
    reset = r;
    @(posedge clk);
    #1;
    if (r) n = 0;
    else n++;
    cmp("modelo_A", sa, modelo(n, 6, 1, 2, 1, 3, 1, 1, 1, 2));
    cmp("modelo_B", sb, modelo(n, 4, 1, 1, 2, 2, 1, 1, 1, 1));
    cmp("modelo_C", sc, modelo(n, 640, 16, 96, 48, 480, 10, 2, 33, 2));
  endtask

  initial begin
    vetor_t tab[22];
    bit     achou;
    int     conta, baixo, ini_b_cnt, pe_b_baixo, vs_baixo, q_ant;

    // Reset entry, start-up and first hsync fall of instance A (10-pixel lines).
    for (int i = 0; i < 3; i++) tab[i] = '{rst: 1'b1, esp: valores_reset()};
    tab[3]  = '{1'b0, mk(1'b0, 0, 1'b1, 1'b1)};
    tab[4]  = '{1'b0, mk(1'b1, 1, 1'b1, 1'b1)};
    tab[5]  = '{1'b0, mk(1'b0, 1, 1'b1, 1'b1)};
    tab[6]  = '{1'b0, mk(1'b1, 2, 1'b1, 1'b1)};
    tab[7]  = '{1'b0, mk(1'b0, 2, 1'b1, 1'b1)};
    tab[8]  = '{1'b0, mk(1'b1, 3, 1'b1, 1'b1)};
    tab[9]  = '{1'b0, mk(1'b0, 3, 1'b1, 1'b1)};
    tab[10] = '{1'b0, mk(1'b1, 4, 1'b1, 1'b1)};
    tab[11] = '{1'b0, mk(1'b0, 4, 1'b1, 1'b1)};
    tab[12] = '{1'b0, mk(1'b1, 5, 1'b1, 1'b1)};
    tab[13] = '{1'b0, mk(1'b0, 5, 1'b1, 1'b1)};
    tab[14] = '{1'b0, mk(1'b1, 6, 1'b0, 1'b1)};
    tab[15] = '{1'b0, mk(1'b0, 6, 1'b0, 1'b1)};
    tab[16] = '{1'b0, mk(1'b1, 7, 1'b0, 1'b0)};
    tab[17] = '{1'b0, mk(1'b0, 7, 1'b0, 1'b0)};
    tab[18] = '{1'b0, mk(1'b1, 8, 1'b0, 1'b0)};
    tab[19] = '{1'b1, valores_reset()};
    tab[20] = '{1'b0, mk(1'b0, 0, 1'b1, 1'b1)};
    tab[21] = '{1'b0, mk(1'b1, 1, 1'b1, 1'b1)};

    for (int i = 0; i < 22; i++) begin
      passo(tab[i].rst);
      cmp($sformatf("tabela[%0d]", i), sa, tab[i].esp);
    end

    // Default timing: line period and hsync width on instance C.
    achou = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      passo(1'b0);
      if (pe_c && col_c == 10'd0) begin achou = 1'b1; break; end
    end
    cmp_int("inicio_linha_C", int'(achou), 1);
    conta = 0; baixo = 0; achou = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      passo(1'b0);
      conta++;
      if (!hs_c) baixo++;
      if (pe_c && col_c == 10'd0) begin achou = 1'b1; break; end
    end
    cmp_int("linha_achada_C", int'(achou), 1);
    cmp_int("periodo_linha_C", conta, 1600);
    cmp_int("hsync_baixo_C", baixo, 192);

    // Frame period on A, vsync width on A, and B's pulses over the same span.
    achou = 1'b0;
    for (int i = 0; i < 400; i++) begin
      passo(1'b0);
      if (ini_a) begin achou = 1'b1; break; end
    end
    cmp_int("inicio_quadro_A", int'(achou), 1);
    conta = 0; ini_b_cnt = 0; pe_b_baixo = 0; vs_baixo = 0; achou = 1'b0;
    for (int i = 0; i < 400; i++) begin
      passo(1'b0);
      conta++;
      if (ini_b) ini_b_cnt++;
      if (!pe_b) pe_b_baixo++;
      if (!vs_a) vs_baixo++;
      if (ini_a) begin achou = 1'b1; break; end
    end
    cmp_int("quadro_achado_A", int'(achou), 1);
    cmp_int("periodo_quadro_A", conta, 120);
    cmp_int("vsync_baixo_A", vs_baixo, 20);
    cmp_int("pulsos_quadro_B", ini_b_cnt, 3);
    cmp_int("pixel_en_baixo_B", pe_b_baixo, 0);

    // Frame counter wrap 255->0 on A, coinciding with inicioQuadro.
    achou = 1'b0; q_ant = int'(qd_a);
    for (int i = 0; i < 32000; i++) begin
      q_ant = int'(qd_a);
      passo(1'b0);
      if (ini_a && qd_a == 8'd0) begin achou = 1'b1; break; end
    end
    cmp_int("wrap_quadro_A", int'(achou), 1);
    cmp_int("quadro_antes_wrap_A", q_ant, 255);

    // Reset in mid-frame on A, then restart.
    achou = 1'b0;
    for (int i = 0; i < 400; i++) begin
      passo(1'b0);
      if (lin_a == 10'd2 && col_a == 10'd4) begin achou = 1'b1; break; end
    end
    cmp_int("meio_quadro_A", int'(achou), 1);
    passo(1'b1);
    cmp("reset_meio_A", sa, valores_reset());
    passo(1'b0);
    cmp("apos_reset_1_A", sa, mk(1'b0, 0, 1'b1, 1'b1));
    passo(1'b0);
    cmp("apos_reset_2_A", sa, mk(1'b1, 1, 1'b1, 1'b1));

    // Random run lengths with random reset bursts, checked against the model.
    for (int k = 0; k < 12; k++) begin
      int corre, segura;
      corre  = int'($urandom_range(1, 400));
      segura = int'($urandom_range(1, 3));
      for (int i = 0; i < corre; i++) passo(1'b0);
      for (int i = 0; i < segura; i++) passo(1'b1);
    end
    for (int i = 0; i < 50; i++) passo(1'b0);

    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

endmodule
